fbuf_capture_ctrl: RTL and testbench
====================================

# fbuf_capture_ctrl

Frame-capture sequencer for the color-detect framebuffer path. It flushes the framebuffer write stage, then arms capture on the next frame-start marker, and counts framebuffer writes until exactly one frame of pixels has landed. It reports frame completion and flags capture errors. It runs in the 125 MHz write-side clock domain and drives the flush input of the framebuffer write interface and the capture gate of the camera-side FIFO writer.

## Interface
- FRAME_PIXELS, 230400: pixels per frame; must equal framebuffer depth.
- FLUSH_CYCLES, 4: cycles o_flush is held; minimum 1.
- TIMEOUT_CYCLES, 2000000: max idle cycles in WAIT_VSYNC/CAPTURE before abort; minimum 2.
- i_clk  in  1  board clock; all logic on rising edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_start  in  1  request capture (level sampled in IDLE); also clears sticky errors.
- i_continuous  in  1  1 = re-arm after each frame; 0 = single shot.
- i_abort  in  1  stop immediately; highest priority after reset.
- i_clr_err  in  1  clear all sticky error flags.
- i_vsync  in  1  frame-start marker, already synchronised to i_clk; rising edge used.
- i_fbuf_wr  in  1  one pulse per pixel written to framebuffer.
- o_flush  out  1  flush to framebuffer write stage.
- o_capture_en  out  1  gate for camera FIFO writes.
- o_busy  out  1  state != IDLE.
- o_frame_done  out  1  one-cycle pulse per completed frame.
- o_pix_count  out  $clog2(FRAME_PIXELS+1)  pixels counted in current frame.
- o_frame_cnt  out  8  completed frames, wraps 255 -> 0.
- o_err_short  out  1  sticky: vsync edge before frame complete.
- o_err_overrun  out  1  sticky: i_fbuf_wr seen outside CAPTURE.
- o_err_timeout  out  1  sticky: timeout expired.

## Operation
- States: IDLE, FLUSH, WAIT_VSYNC, CAPTURE, DONE.
- Edge detect: vsync_q <= i_vsync; rise = i_vsync & ~vsync_q; vsync_q resets to 1, so a high vsync at reset exit is not an edge.
- IDLE: on i_start or i_continuous, load flush counter with FLUSH_CYCLES-1, clear errors if i_start, go to FLUSH.
- FLUSH: o_flush = 1. Decrement counter; at 0 go to WAIT_VSYNC and load timeout counter.
- WAIT_VSYNC: on rise, clear o_pix_count and go to CAPTURE (o_capture_en = 1). The timeout counter decrements every cycle.
- CAPTURE: each i_fbuf_wr increments o_pix_count and reloads the timeout counter.
  - Write with o_pix_count == FRAME_PIXELS-1 goes to DONE; o_pix_count becomes FRAME_PIXELS.
  - A rise before completion sets o_err_short and goes to FLUSH to resynchronise. Completion on the same cycle as rise wins; no error is raised.
- DONE (one cycle): o_frame_done = 1, o_frame_cnt += 1. Then WAIT_VSYNC if i_continuous, else IDLE. No flush is needed between continuous frames because the write address wraps at FRAME_PIXELS.
- Timeout reaching 0 in WAIT_VSYNC/CAPTURE: set o_err_timeout, go to IDLE.
- i_fbuf_wr in IDLE, FLUSH, WAIT_VSYNC or DONE sets o_err_overrun; it is not counted. In FLUSH it is ignored without error for the first 2 cycles (pipeline drain).
- i_abort in any state: go to IDLE; o_flush and o_capture_en go to 0 next cycle; no o_frame_done; counters hold.
- Error set and i_clr_err on the same cycle: set wins.

## Timing
- Reset (i_rstn = 0 at an edge): state IDLE; all outputs 0; counters 0; vsync_q = 1.
- All outputs are registered and decoded from the registered state.
- i_start high at edge N in IDLE: o_flush = 1 for edges N+1 .. N+FLUSH_CYCLES; state WAIT_VSYNC from edge N+FLUSH_CYCLES+1.
- i_vsync rises at sample edge M: o_capture_en = 1 from edge M+1.
- Final write sampled at edge K: o_frame_done = 1 for exactly edge K+1, o_capture_en = 0 at K+1, o_frame_cnt updated at K+1.
- o_pix_count reflects each write one edge after it is sampled.
- Reset mid-frame: same as reset; no o_frame_done.

## Test plan
- Single shot (FRAME_PIXELS=16, FLUSH_CYCLES=4): i_start pulse, then vsync rise, then 16 wr pulses -> o_flush high for 4 cycles; o_frame_done 1 cycle after the 16th wr; o_frame_cnt = 1; return to IDLE; no errors.
- Continuous: i_continuous=1, 3 frames of 16 wr each separated by vsync -> 3 done pulses; o_frame_cnt = 3; only one flush burst at start.
- Short frame: vsync rise after 10 wr -> o_err_short = 1; FLUSH re-entered; next full frame completes with o_pix_count = 16.
- Overrun/clear: wr pulse in WAIT_VSYNC -> o_err_overrun = 1 and o_pix_count unchanged; i_clr_err -> 0; simultaneous new wr with i_clr_err -> stays 1.
- Timeout (TIMEOUT_CYCLES=64): arm, no vsync -> o_err_timeout = 1 after 64 cycles in WAIT_VSYNC; state IDLE; o_busy = 0.
- Abort/reset: i_abort after 8 wr -> o_capture_en = 0 next cycle, no done pulse; repeat with i_rstn low -> all outputs 0.

Source files
------------

// File: rtl/fbuf_capture_ctrl.sv
// Frame-capture sequencer: flush, arm on vsync rise, count one frame of
// framebuffer writes, report completion and sticky capture errors.
module fbuf_capture_ctrl #(
  parameter int FRAME_PIXELS   = 230400,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int PW = $clog2(FRAME_PIXELS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_continuous,
  input  logic          i_abort,
  input  logic          i_clr_err,
  input  logic          i_vsync,
  input  logic          i_fbuf_wr,
  output logic          o_flush,
  output logic          o_capture_en,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic [PW-1:0] o_pix_count,
  output logic [7:0]    o_frame_cnt,
  output logic          o_err_short,
  output logic          o_err_overrun,
  output logic          o_err_timeout
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FL_LOAD  = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);
  localparam logic [PW-1:0] PIX_FULL = PW'(FRAME_PIXELS);

  typedef enum logic [2:0] {
    IDLE, FLUSH, WAIT_VSYNC, CAPTURE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    age_q, age_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [7:0]    frames_q, frames_d;
  logic          short_q, over_q, tout_q;
  logic          short_d, over_d, tout_d;
  logic          set_short, set_over, set_tout, clr;
  logic          vsync_q, rise;

  assign rise = i_vsync & ~vsync_q;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    tmo_d     = tmo_q;
    age_d     = age_q;
    pix_d     = pix_q;
    frames_d  = frames_q;
    set_short = 1'b0;
    set_over  = 1'b0;
    set_tout  = 1'b0;
    clr       = i_clr_err;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          set_over = i_fbuf_wr;
          if (i_start | i_continuous) begin
            state_d = FLUSH;
            flush_d = FL_LOAD;
            age_d   = 2'd0;
            clr     = i_clr_err | i_start;
          end
        end
        FLUSH: begin
          // writes still draining out of the pipe are tolerated briefly
          set_over = i_fbuf_wr & (age_q == 2'd2);
          if (age_q != 2'd2) age_d = age_q + 2'd1;
          if (flush_q == '0) begin
            state_d = WAIT_VSYNC;
            tmo_d   = TO_LOAD;
          end else begin
            flush_d = flush_q - FW'(1);
          end
        end
        WAIT_VSYNC: begin
          set_over = i_fbuf_wr;
          if (rise) begin
            state_d = CAPTURE;
            pix_d   = '0;
            tmo_d   = TO_LOAD;
          end else if (tmo_q == '0) begin
            state_d  = IDLE;
            set_tout = 1'b1;
          end else begin
            tmo_d = tmo_q - TW'(1);
          end
        end
        CAPTURE: begin
          // completion beats a coincident vsync edge
          if (i_fbuf_wr && pix_q == PIX_LAST) begin
            state_d  = DONE;
            pix_d    = PIX_FULL;
            frames_d = frames_q + 8'd1;
          end else if (rise) begin
            state_d   = FLUSH;
            flush_d   = FL_LOAD;
            age_d     = 2'd0;
            set_short = 1'b1;
          end else if (i_fbuf_wr) begin
            pix_d = pix_q + PW'(1);
            tmo_d = TO_LOAD;
          end else if (tmo_q == '0) begin
            state_d  = IDLE;
            set_tout = 1'b1;
          end else begin
            tmo_d = tmo_q - TW'(1);
          end
        end
        DONE: begin
          set_over = i_fbuf_wr;
          if (i_continuous) begin
            state_d = WAIT_VSYNC;
            tmo_d   = TO_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    short_d = set_short | (short_q & ~clr);
    over_d  = set_over  | (over_q  & ~clr);
    tout_d  = set_tout  | (tout_q  & ~clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      flush_q  <= '0;
      tmo_q    <= '0;
      age_q    <= '0;
      pix_q    <= '0;
      frames_q <= '0;
      short_q  <= 1'b0;
      over_q   <= 1'b0;
      tout_q   <= 1'b0;
      vsync_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      tmo_q    <= tmo_d;
      age_q    <= age_d;
      pix_q    <= pix_d;
      frames_q <= frames_d;
      short_q  <= short_d;
      over_q   <= over_d;
      tout_q   <= tout_d;
      vsync_q  <= i_vsync;
    end
  end

  assign o_flush       = (state_q == FLUSH);
  assign o_capture_en  = (state_q == CAPTURE);
  assign o_busy        = (state_q != IDLE);
  assign o_frame_done  = (state_q == DONE);
  assign o_pix_count   = pix_q;
  assign o_frame_cnt   = frames_q;
  assign o_err_short   = short_q;
  assign o_err_overrun = over_q;
  assign o_err_timeout = tout_q;

endmodule

// File: tb/tb_fbuf_capture_ctrl.sv
// Bench for fbuf_capture_ctrl: vector table applied through a scoreboard,
// plus pulse/flush counters checked between scenarios.
module tb_fbuf_capture_ctrl;

  localparam int FP = 16;
  localparam int FC = 4;
  localparam int TO = 64;
  localparam int PW = $clog2(FP + 1);

  localparam bit [6:0] NONE = 7'b0000000;
  localparam bit [6:0] RS   = 7'b1000000;
  localparam bit [6:0] ST   = 7'b0100000;
  localparam bit [6:0] CO   = 7'b0010000;
  localparam bit [6:0] AB   = 7'b0001000;
  localparam bit [6:0] CL   = 7'b0000100;
  localparam bit [6:0] VS   = 7'b0000010;
  localparam bit [6:0] WR   = 7'b0000001;

  // {flush, capture_en, busy, frame_done}
  localparam bit [3:0] O_ID = 4'b0000;
  localparam bit [3:0] O_FL = 4'b1010;
  localparam bit [3:0] O_WT = 4'b0010;
  localparam bit [3:0] O_CP = 4'b0110;
  localparam bit [3:0] O_DN = 4'b0011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic clr = 1'b0, vsync = 1'b0, wr = 1'b0;
  logic flush, cap, busy, done;
  logic [PW-1:0] pix;
  logic [7:0] frames;
  logic e_short, e_over, e_tmo;

  always #5 clk = ~clk;

  fbuf_capture_ctrl #(
    .FRAME_PIXELS(FP),
    .FLUSH_CYCLES(FC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_start(start),
    .i_continuous(cont),
    .i_abort(abort),
    .i_clr_err(clr),
    .i_vsync(vsync),
    .i_fbuf_wr(wr),
    .o_flush(flush),
    .o_capture_en(cap),
    .o_busy(busy),
    .o_frame_done(done),
    .o_pix_count(pix),
    .o_frame_cnt(frames),
    .o_err_short(e_short),
    .o_err_overrun(e_over),
    .o_err_timeout(e_tmo)
  );

  typedef struct {
    bit [6:0] in;
    int       reps;
    bit [3:0] o;
    int       pix;
    int       frames;
    bit [2:0] err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int vec_no = 0;
  int done_pulses = 0;
  int flush_cyc = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (done) done_pulses++;
      if (flush) flush_cyc++;
    end
  end

  function automatic void add(bit [6:0] in, int reps, bit [3:0] o,
                              int p, int f, bit [2:0] err);
    vec_t v;
    v.in = in; v.reps = reps; v.o = o;
    v.pix = p; v.frames = f; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d",
               nm, vec_no, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    e = sb.pop_front();
    chk("flush", 32'(flush), 32'(e.o[3]));
    chk("capture_en", 32'(cap), 32'(e.o[2]));
    chk("busy", 32'(busy), 32'(e.o[1]));
    chk("frame_done", 32'(done), 32'(e.o[0]));
    chk("pix_count", 32'(pix), e.pix);
    chk("frame_cnt", 32'(frames), e.frames);
    chk("errors", 32'({e_short, e_over, e_tmo}), 32'(e.err));
  endtask

  task automatic apply(vec_t v);
    rstn  = ~v.in[6];
    start = v.in[5];
    cont  = v.in[4];
    abort = v.in[3];
    clr   = v.in[2];
    vsync = v.in[1];
    wr    = v.in[0];
    sb.push_back(v);
    repeat (v.reps) @(posedge clk);
    #1;
    check_out();
    vec_no++;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    // reset state and single-shot frame
    add(RS, 2, O_ID, 0, 0, 0);
    add(NONE, 1, O_ID, 0, 0, 0);
    add(ST, 1, O_FL, 0, 0, 0);
    add(NONE, 3, O_FL, 0, 0, 0);
    add(NONE, 1, O_WT, 0, 0, 0);
    add(VS, 1, O_CP, 0, 0, 0);
    add(VS | WR, 15, O_CP, 15, 0, 0);
    add(WR, 1, O_DN, 16, 1, 0);
    add(NONE, 1, O_ID, 16, 1, 0);
    run_tbl();
    chk("single_done_pulses", done_pulses, 1);
    chk("single_flush_cycles", flush_cyc, FC);

    // continuous: three frames, one flush burst
    add(CO, 1, O_FL, 16, 1, 0);
    add(CO, 4, O_WT, 16, 1, 0);
    for (int f = 0; f < 3; f++) begin
      add(CO | VS, 1, O_CP, 0, 1 + f, 0);
      add(CO | WR, 16, O_DN, 16, 2 + f, 0);
      if (f == 2) add(NONE, 1, O_ID, 16, 4, 0);
      else add(CO, 1, O_WT, 16, 2 + f, 0);
    end
    run_tbl();
    chk("cont_done_pulses", done_pulses, 4);
    chk("cont_flush_cycles", flush_cyc, 2 * FC);

    // short frame then resync
    add(ST, 1, O_FL, 16, 4, 0);
    add(NONE, 4, O_WT, 16, 4, 0);
    add(VS, 1, O_CP, 0, 4, 0);
    add(WR, 10, O_CP, 10, 4, 0);
    add(VS, 1, O_FL, 10, 4, 3'b100);
    add(VS, 4, O_WT, 10, 4, 3'b100);
    add(NONE, 1, O_WT, 10, 4, 3'b100);
    add(VS, 1, O_CP, 0, 4, 3'b100);
    add(WR, 16, O_DN, 16, 5, 3'b100);
    add(NONE, 1, O_ID, 16, 5, 3'b100);
    run_tbl();
    chk("short_done_pulses", done_pulses, 5);
    chk("short_flush_cycles", flush_cyc, 4 * FC);

    // overrun, drain window, clear, set-beats-clear
    add(CL, 1, O_ID, 16, 5, 0);
    add(ST, 1, O_FL, 16, 5, 0);
    add(WR, 2, O_FL, 16, 5, 0);
    add(NONE, 2, O_WT, 16, 5, 0);
    add(WR, 1, O_WT, 16, 5, 3'b010);
    add(CL, 1, O_WT, 16, 5, 0);
    add(CL | WR, 1, O_WT, 16, 5, 3'b010);
    add(AB, 1, O_ID, 16, 5, 3'b010);

    // abort mid-frame
    add(ST, 1, O_FL, 16, 5, 0);
    add(NONE, 4, O_WT, 16, 5, 0);
    add(VS, 1, O_CP, 0, 5, 0);
    add(WR, 8, O_CP, 8, 5, 0);
    add(AB, 1, O_ID, 8, 5, 0);
    add(NONE, 2, O_ID, 8, 5, 0);
    run_tbl();
    chk("abort_done_pulses", done_pulses, 5);

    // timeout in WAIT_VSYNC
    add(ST, 1, O_FL, 8, 5, 0);
    add(NONE, 4, O_WT, 8, 5, 0);
    add(NONE, TO - 1, O_WT, 8, 5, 0);
    add(NONE, 1, O_ID, 8, 5, 3'b001);
    add(NONE, 1, O_ID, 8, 5, 3'b001);

    // reset mid-frame, then high vsync at reset exit is not an edge
    add(CO, 1, O_FL, 8, 5, 3'b001);
    add(CO, 4, O_WT, 8, 5, 3'b001);
    add(VS, 1, O_CP, 0, 5, 3'b001);
    add(WR, 8, O_CP, 8, 5, 3'b001);
    add(RS | VS, 1, O_ID, 0, 0, 0);
    add(VS, 1, O_ID, 0, 0, 0);
    add(ST | VS, 1, O_FL, 0, 0, 0);
    add(VS, 4, O_WT, 0, 0, 0);
    add(VS, 2, O_WT, 0, 0, 0);
    add(AB, 1, O_ID, 0, 0, 0);
    run_tbl();
    chk("final_done_pulses", done_pulses, 5);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
